// File: rtl/tmds_encoder_array.sv
// tmds_encoder_array: NUM_CH-lane TMDS video/control/TERC4/guard encoder, 3-stage pipeline.
// Define TMDS_DISP_MON_EN to add the disp/disp_err disparity monitor outputs.
module tmds_encoder_array #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ce,
  input  logic [1:0]              mode,
  input  logic                    guard_di,
  input  logic [NUM_CH*8-1:0]     din,
  input  logic [NUM_CH*2-1:0]     ctrl,
  input  logic [NUM_CH*4-1:0]     terc,
  output logic [NUM_CH*10-1:0]    dout
`ifdef TMDS_DISP_MON_EN
  ,
  output logic [NUM_CH*CNT_W-1:0] disp,
  output logic                    disp_err
`endif
);

  localparam logic [1:0] M_CTL = 2'b00;
  localparam logic [1:0] M_VID = 2'b01;
  localparam logic [1:0] M_TRC = 2'b10;
  localparam logic [9:0] CTL00 = 10'b1101010100;
  localparam logic [9:0] GB_A  = 10'b1011001100;
  localparam logic [9:0] GB_B  = 10'b0100110011;

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  function automatic logic [8:0] qm_gen(input logic [7:0] d);
    logic [8:0] q;
    logic [3:0] n;
    logic       xn;
    n = ones8(d);
    xn = (n > 4'd4) || (n == 4'd4 && !d[0]);
    q = '0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++)
      q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = ~xn;
    return q;
  endfunction

  function automatic logic [9:0] ctl_code(input logic [1:0] c);
    logic [9:0] s;
    unique case (c)
      2'b00: s = 10'b1101010100;
      2'b01: s = 10'b0010101011;
      2'b10: s = 10'b0101010100;
      default: s = 10'b1010101011;
    endcase
    return s;
  endfunction

  function automatic logic [9:0] terc4(input logic [3:0] t);
    logic [9:0] s;
    unique case (t)
      4'h0: s = 10'b1010011100;
      4'h1: s = 10'b1001100011;
      4'h2: s = 10'b1011100100;
      4'h3: s = 10'b1011100010;
      4'h4: s = 10'b0101110001;
      4'h5: s = 10'b0100011110;
      4'h6: s = 10'b0110001110;
      4'h7: s = 10'b0100111100;
      4'h8: s = 10'b1011001100;
      4'h9: s = 10'b0100111001;
      4'hA: s = 10'b0110011100;
      4'hB: s = 10'b1011000110;
      4'hC: s = 10'b1010001110;
      4'hD: s = 10'b1001110001;
      4'hE: s = 10'b0101100011;
      default: s = 10'b1011000011;
    endcase
    return s;
  endfunction

  logic [1:0]              s1_mode, s2_mode;
  logic                    s1_gdi, s2_gdi;
  logic [NUM_CH*8-1:0]     s1_din;
  logic [NUM_CH*2-1:0]     s1_ctrl, s2_ctrl;
  logic [NUM_CH*4-1:0]     s1_terc, s2_terc;
  logic [NUM_CH*9-1:0]     s2_qm, qm_d;
  logic [NUM_CH*CNT_W-1:0] cnt, cnt_d;
  logic [NUM_CH*10-1:0]    dout_d;

  always_comb begin
    qm_d = '0;
    for (int k = 0; k < NUM_CH; k++)
      qm_d[9*k +: 9] = qm_gen(s1_din[8*k +: 8]);
  end

  logic [8:0]       qm;
  logic [3:0]       n1, n0;
  logic [CNT_W-1:0] c, diff, tq, tnq, cn;
  logic [9:0]       sym;

  // Disparity decision; any non-video symbol restarts the lane at cnt=0.
  always_comb begin
    dout_d = '0;
    cnt_d  = '0;
    qm = '0; n1 = '0; n0 = '0;
    c = '0; diff = '0; tq = '0; tnq = '0; cn = '0;
    sym = CTL00;
    for (int k = 0; k < NUM_CH; k++) begin
      qm   = s2_qm[9*k +: 9];
      n1   = ones8(qm[7:0]);
      n0   = 4'd8 - n1;
      diff = CNT_W'(n1) - CNT_W'(n0);
      c    = cnt[CNT_W*k +: CNT_W];
      tq   = qm[8] ? CNT_W'(2) : '0;
      tnq  = qm[8] ? '0 : CNT_W'(2);
      cn   = '0;
      sym  = CTL00;
      unique case (s2_mode)
        M_VID: begin
          if (c == '0 || n1 == n0) begin
            sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            cn  = qm[8] ? c + diff : c - diff;
          end else if ((!c[CNT_W-1] && n1 > n0) ||
                       (c[CNT_W-1] && n0 > n1)) begin
            sym = {1'b1, qm[8], ~qm[7:0]};
            cn  = c + tq - diff;
          end else begin
            sym = {1'b0, qm[8], qm[7:0]};
            cn  = c + diff - tnq;
          end
        end
        M_CTL: sym = ctl_code(s2_ctrl[2*k +: 2]);
        M_TRC: sym = terc4(s2_terc[4*k +: 4]);
        default: begin
          if (!s2_gdi)
            sym = (k % 3 == 1) ? GB_B : GB_A;
          else if (k % 3 == 0)
            sym = terc4({2'b11, s2_ctrl[2*k +: 2]});
          else
            sym = GB_B;
        end
      endcase
      dout_d[10*k +: 10]      = sym;
      cnt_d[CNT_W*k +: CNT_W] = cn;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_mode <= M_CTL;
      s1_gdi  <= 1'b0;
      s1_din  <= '0;
      s1_ctrl <= '0;
      s1_terc <= '0;
      s2_mode <= M_CTL;
      s2_gdi  <= 1'b0;
      s2_ctrl <= '0;
      s2_terc <= '0;
      s2_qm   <= '0;
      cnt     <= '0;
      dout    <= {NUM_CH{CTL00}};
    end else if (ce) begin
      s1_mode <= mode;
      s1_gdi  <= guard_di;
      s1_din  <= din;
      s1_ctrl <= ctrl;
      s1_terc <= terc;
      s2_mode <= s1_mode;
      s2_gdi  <= s1_gdi;
      s2_ctrl <= s1_ctrl;
      s2_terc <= s1_terc;
      s2_qm   <= qm_d;
      cnt     <= cnt_d;
      dout    <= dout_d;
    end
  end

`ifdef TMDS_DISP_MON_EN
  logic                    over;
  logic signed [CNT_W-1:0] sv;

  assign disp = cnt;

  always_comb begin
    over = 1'b0;
    sv   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sv   = cnt[CNT_W*k +: CNT_W];
      over = over | (sv > $signed(CNT_W'(8)))
                  | (sv < -$signed(CNT_W'(8)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      disp_err <= 1'b0;
    else if (over)
      disp_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_tmds_encoder_array.sv
// tb_tmds_encoder_array: scoreboard bench for tmds_encoder_array.
// Expectations are queued with their due cycle; a negedge monitor pops and compares.
module tb_tmds_encoder_array;
  localparam int NUM_CH = 3;
  localparam int CNT_W  = 5;
  localparam int W      = NUM_CH*10;

  logic                    clk = 1'b0;
  logic                    rst, ce, guard_di;
  logic [1:0]              mode;
  logic [NUM_CH*8-1:0]     din;
  logic [NUM_CH*2-1:0]     ctrl;
  logic [NUM_CH*4-1:0]     terc;
  logic [W-1:0]            dout;
`ifdef TMDS_DISP_MON_EN
  logic [NUM_CH*CNT_W-1:0] disp;
  logic                    disp_err;
`endif

  always #5 clk = ~clk;

  tmds_encoder_array #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ce(ce), .mode(mode),
    .guard_di(guard_di), .din(din), .ctrl(ctrl),
    .terc(terc), .dout(dout)
`ifdef TMDS_DISP_MON_EN
    , .disp(disp), .disp_err(disp_err)
`endif
  );

  typedef struct {
    int               due;
    logic [W-1:0]     exp;
    string            nm;
    bit               dc;
    logic [CNT_W-1:0] dp;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] rep(input logic [9:0] s);
    return {NUM_CH{s}};
  endfunction

  task automatic want(input int due, input logic [W-1:0] e, input string n);
    sb.push_back('{due: due, exp: e, nm: n, dc: 1'b0, dp: '0});
  endtask

  task automatic want_d(input int due, input logic [W-1:0] e,
                        input logic [CNT_W-1:0] p, input string n);
    sb.push_back('{due: due, exp: e, nm: n, dc: 1'b1, dp: p});
  endtask

  task automatic drive(input logic r, input logic c, input logic [1:0] m,
                       input logic g, input logic [7:0] d,
                       input logic [1:0] cc, input logic [3:0] t);
    rst = r; ce = c; mode = m; guard_di = g;
    din = {NUM_CH{d}}; ctrl = {NUM_CH{cc}}; terc = {NUM_CH{t}};
    @(posedge clk);
    #1;
  endtask

  task automatic vid(input logic [7:0] d, input logic [9:0] e, input string n);
    drive(1'b0, 1'b1, 2'b01, 1'b0, d, 2'b00, 4'h0);
    want(cyc + 2, rep(e), n);
  endtask

  task automatic vid_d(input logic [7:0] d, input logic [9:0] e,
                       input logic [CNT_W-1:0] p, input string n);
    drive(1'b0, 1'b1, 2'b01, 1'b0, d, 2'b00, 4'h0);
    want_d(cyc + 2, rep(e), p, n);
  endtask

  task automatic ctl(input logic [1:0] c, input logic [9:0] e, input string n);
    drive(1'b0, 1'b1, 2'b00, 1'b0, 8'h00, c, 4'h0);
    want(cyc + 2, rep(e), n);
  endtask

  task automatic trc(input logic [3:0] t, input logic [9:0] e, input string n);
    drive(1'b0, 1'b1, 2'b10, 1'b0, 8'h00, 2'b00, t);
    want(cyc + 2, rep(e), n);
  endtask

  task automatic grd(input logic g, input logic [1:0] c,
                     input logic [W-1:0] e, input string n);
    drive(1'b0, 1'b1, 2'b11, g, 8'h00, c, 4'h0);
    want(cyc + 2, e, n);
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due < cyc) begin
        checks++;
        $display("FAIL %s: not observed at cycle %0d (now %0d)",
                 sb[i].nm, sb[i].due, cyc);
        sb.delete(i);
      end else if (sb[i].due == cyc) begin
        checks++;
        if (dout === sb[i].exp) passed++;
        else $display("FAIL %s: dout=%b expected %b", sb[i].nm, dout, sb[i].exp);
`ifdef TMDS_DISP_MON_EN
        if (sb[i].dc) begin
          checks++;
          if (disp === {NUM_CH{sb[i].dp}} && disp_err === 1'b0) passed++;
          else $display("FAIL %s_disp: disp=%b err=%b expected %b err=0",
                        sb[i].nm, disp, disp_err, {NUM_CH{sb[i].dp}});
        end
`endif
        sb.delete(i);
      end
    end
  end

  initial begin
    rst = 1'b1; ce = 1'b1; mode = 2'b00; guard_di = 1'b0;
    din = '0; ctrl = '0; terc = '0;

    drive(1'b1, 1'b1, 2'b00, 1'b0, 8'h00, 2'b00, 4'h0);
    want_d(cyc, rep(10'b1101010100), 5'd0, "rst_e1");
    drive(1'b1, 1'b1, 2'b00, 1'b0, 8'h00, 2'b00, 4'h0);
    want_d(cyc, rep(10'b1101010100), 5'd0, "rst_e2");
    drive(1'b0, 1'b1, 2'b00, 1'b0, 8'h00, 2'b00, 4'h0);
    want(cyc, rep(10'b1101010100), "post_rst");

    ctl(2'b00, 10'b1101010100, "ctl00");
    vid(8'h00, 10'b0100000000, "z0");
    vid(8'h00, 10'b1111111111, "z1");
    vid(8'h00, 10'b0100000000, "z2");
    vid(8'h00, 10'b1111111111, "z3");

    ctl(2'b00, 10'b1101010100, "ctl00_b");
    vid(8'hFF, 10'b1000000000, "ff0");
    vid(8'hFF, 10'b0011111111, "ff1");
    vid(8'hFF, 10'b0011111111, "ff2");

    ctl(2'b01, 10'b0010101011, "ctl01");
    vid(8'hF0, 10'b1000000101, "f0_0");
    vid(8'hF0, 10'b0011111010, "f0_1");

    ctl(2'b10, 10'b0101010100, "ctl10");
    vid_d(8'h03, 10'b0100000001, 5'b11010, "d03_0");
    vid_d(8'h03, 10'b1111111110, 5'b00010, "d03_1");
    vid_d(8'h03, 10'b0100000001, 5'b11100, "d03_2");

    ctl(2'b11, 10'b1010101011, "ctl11");
    vid(8'h03, 10'b0100000001, "sw_v0");
    ctl(2'b00, 10'b1101010100, "sw_c");
    vid(8'h03, 10'b0100000001, "sw_v1");

    trc(4'h0, 10'b1010011100, "t0");
    trc(4'hF, 10'b1011000011, "tf");
    trc(4'h5, 10'b0100011110, "t5");

    grd(1'b0, 2'b00, {10'b1011001100, 10'b0100110011, 10'b1011001100}, "gv");
    grd(1'b1, 2'b10, {10'b0100110011, 10'b0100110011, 10'b0101100011}, "gdi10");
    grd(1'b1, 2'b01, {10'b0100110011, 10'b0100110011, 10'b1001110001}, "gdi01");

    drive(1'b0, 1'b1, 2'b10, 1'b0, 8'h00, 2'b00, 4'hA);
    drive(1'b0, 1'b1, 2'b10, 1'b0, 8'h00, 2'b00, 4'hB);
    drive(1'b0, 1'b1, 2'b10, 1'b0, 8'h00, 2'b00, 4'h1);
    want(cyc, rep(10'b0110011100), "ce_a");
    drive(1'b0, 1'b0, 2'b10, 1'b0, 8'h00, 2'b00, 4'h2);
    want(cyc, rep(10'b0110011100), "ce_hold0");
    drive(1'b0, 1'b1, 2'b10, 1'b0, 8'h00, 2'b00, 4'h3);
    want(cyc, rep(10'b1011000110), "ce_c");
    drive(1'b0, 1'b0, 2'b10, 1'b0, 8'h00, 2'b00, 4'h4);
    want(cyc, rep(10'b1011000110), "ce_hold1");
    drive(1'b0, 1'b1, 2'b10, 1'b0, 8'h00, 2'b00, 4'h5);
    want(cyc, rep(10'b1001100011), "ce_e");
    drive(1'b0, 1'b1, 2'b10, 1'b0, 8'h00, 2'b00, 4'h6);
    want(cyc, rep(10'b1011100010), "ce_f");
    drive(1'b0, 1'b1, 2'b10, 1'b0, 8'h00, 2'b00, 4'h7);
    want(cyc, rep(10'b0100011110), "ce_g");

    for (int i = 0; i < 3; i++)
      drive(1'b0, 1'b1, 2'b01, 1'b0, 8'h03, 2'b00, 4'h0);
    drive(1'b1, 1'b0, 2'b01, 1'b0, 8'h03, 2'b00, 4'h0);
    want(cyc, rep(10'b1101010100), "mid_rst");
    drive(1'b0, 1'b1, 2'b01, 1'b0, 8'h00, 2'b00, 4'h0);
    want(cyc, rep(10'b1101010100), "mid_r1");
    want(cyc + 2, rep(10'b0100000000), "mid_v0");
    drive(1'b0, 1'b1, 2'b01, 1'b0, 8'h00, 2'b00, 4'h0);
    want(cyc, rep(10'b1101010100), "mid_r2");
    want(cyc + 2, rep(10'b1111111111), "mid_v1");

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    while (sb.size() > 0) begin
      checks++;
      $display("FAIL %s: timed out waiting for output", sb[0].nm);
      void'(sb.pop_front());
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
